// File: rtl/fpmul_result_q.sv
// Result stage for the FP32 multiplier: classifies each result word and queues it with its flags.
// Also keeps sticky exception flags and saturating event counters.
module fpmul_result_q #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [31:0]              fp_Z,
  input  logic                     ovrf,
  input  logic                     udrf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [2:0]               out_class,
  output logic                     out_ovrf,
  output logic                     out_udrf,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stat,
  output logic                     sticky_ovrf,
  output logic                     sticky_udrf,
  output logic                     sticky_nan,
  output logic                     sticky_drop,
  output logic [CNT_W-1:0]         ovrf_cnt,
  output logic [CNT_W-1:0]         udrf_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 37;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] ovrf_cnt_q, ovrf_cnt_d, udrf_cnt_q, udrf_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             st_ovrf_q, st_ovrf_d, st_udrf_q, st_udrf_d;
  logic             st_nan_q, st_nan_d, st_drop_q, st_drop_d;

  logic [2:0]       in_class;
  logic             pop, push_ok, drop, in_nan;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] ovrf_base, udrf_base, drop_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    in_class = CLS_NORM;
    if (fp_Z[30:23] == 8'h00) begin
      in_class = (fp_Z[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    end else if (fp_Z[30:23] == 8'hFF) begin
      if (fp_Z[22:0] == 23'd0) in_class = CLS_INF;
      else if (fp_Z[22])       in_class = CLS_QNAN;
      else                     in_class = CLS_SNAN;
    end
  end

  assign in_nan    = (in_class == CLS_QNAN) || (in_class == CLS_SNAN);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push_ok   = in_valid && ((level_q < LW'(DEPTH)) || pop);
  assign drop      = in_valid && !push_ok;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
  end

  // Clear first, then let a same-cycle event land on the cleared value.
  always_comb begin
    ovrf_base  = clr_stat ? '0 : ovrf_cnt_q;
    udrf_base  = clr_stat ? '0 : udrf_cnt_q;
    drop_base  = clr_stat ? '0 : drop_cnt_q;
    ovrf_cnt_d = (push_ok && ovrf) ? sat_inc(ovrf_base) : ovrf_base;
    udrf_cnt_d = (push_ok && udrf) ? sat_inc(udrf_base) : udrf_base;
    drop_cnt_d = drop ? sat_inc(drop_base) : drop_base;
    st_ovrf_d  = (st_ovrf_q && !clr_stat) || (push_ok && ovrf);
    st_udrf_d  = (st_udrf_q && !clr_stat) || (push_ok && udrf);
    st_nan_d   = (st_nan_q  && !clr_stat) || (push_ok && in_nan);
    st_drop_d  = (st_drop_q && !clr_stat) || drop;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {fp_Z, in_class, ovrf, udrf};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovrf_cnt_q <= '0;
      udrf_cnt_q <= '0;
      drop_cnt_q <= '0;
      st_ovrf_q  <= 1'b0;
      st_udrf_q  <= 1'b0;
      st_nan_q   <= 1'b0;
      st_drop_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovrf_cnt_q <= ovrf_cnt_d;
      udrf_cnt_q <= udrf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      st_ovrf_q  <= st_ovrf_d;
      st_udrf_q  <= st_udrf_d;
      st_nan_q   <= st_nan_d;
      st_drop_q  <= st_drop_d;
    end
  end

  // Head fields read as zero while empty so reset leaves every output at 0.
  assign head        = mem[rd_ptr_q];
  assign out_data    = out_valid ? head[36:5] : 32'd0;
  assign out_class   = out_valid ? head[4:2]  : 3'd0;
  assign out_ovrf    = out_valid && head[1];
  assign out_udrf    = out_valid && head[0];
  assign level       = level_q;
  assign ovrf_cnt    = ovrf_cnt_q;
  assign udrf_cnt    = udrf_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign sticky_ovrf = st_ovrf_q;
  assign sticky_udrf = st_udrf_q;
  assign sticky_nan  = st_nan_q;
  assign sticky_drop = st_drop_q;

endmodule

// File: tb/tb_fpmul_result_q.sv
// Directed bench for fpmul_result_q: default instance plus a CNT_W=4 instance for saturation.
module tb_fpmul_result_q;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0, ovrf = 1'b0, udrf = 1'b0, out_ready = 1'b0, clr_stat = 1'b0;
  logic [31:0] fp_z = 32'd0;
  logic        out_valid, out_ovrf, out_udrf;
  logic [31:0] out_data;
  logic [2:0]  out_class, level;
  logic        sticky_ovrf, sticky_udrf, sticky_nan, sticky_drop;
  logic [15:0] ovrf_cnt, udrf_cnt, drop_cnt;

  logic        in_valid4 = 1'b0, ovrf4 = 1'b0, out_ready4 = 1'b1;
  logic        out_valid4, out_ovrf4, out_udrf4;
  logic [31:0] out_data4;
  logic [2:0]  out_class4, level4;
  logic        sticky_ovrf4, sticky_udrf4, sticky_nan4, sticky_drop4;
  logic [3:0]  ovrf_cnt4, udrf_cnt4, drop_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpmul_result_q #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .fp_Z(fp_z), .ovrf(ovrf), .udrf(udrf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .out_ovrf(out_ovrf), .out_udrf(out_udrf), .level(level), .clr_stat(clr_stat),
    .sticky_ovrf(sticky_ovrf), .sticky_udrf(sticky_udrf), .sticky_nan(sticky_nan),
    .sticky_drop(sticky_drop), .ovrf_cnt(ovrf_cnt), .udrf_cnt(udrf_cnt), .drop_cnt(drop_cnt)
  );

  fpmul_result_q #(.DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .fp_Z(32'h3F800000), .ovrf(ovrf4), .udrf(1'b0),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_class(out_class4),
    .out_ovrf(out_ovrf4), .out_udrf(out_udrf4), .level(level4), .clr_stat(1'b0),
    .sticky_ovrf(sticky_ovrf4), .sticky_udrf(sticky_udrf4), .sticky_nan(sticky_nan4),
    .sticky_drop(sticky_drop4), .ovrf_cnt(ovrf_cnt4), .udrf_cnt(udrf_cnt4), .drop_cnt(drop_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic ov, input logic ud);
    in_valid = 1'b1; fp_z = w; ovrf = ov; udrf = ud;
    tick();
    in_valid = 1'b0; ovrf = 1'b0; udrf = 1'b0;
    $display("push 0x%08h ovrf=%0b udrf=%0b -> level=%0d", w, ov, ud, level);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] vec [4];
  logic [2:0]  cls [4];

  initial begin
    #1 rstn = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_cnts", {ovrf_cnt, udrf_cnt} | {16'd0, drop_cnt}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_ovrf, sticky_udrf, sticky_nan, sticky_drop}, 32'd0);
    rstn = 1'b1;
    tick();

    // 1: single push, hold while not ready
    push(32'h3F800000, 1'b0, 1'b0);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", out_data, 32'h3F800000);
    chk("t1_class", {29'd0, out_class}, 32'd2);
    chk("t1_level", {29'd0, level}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_data", out_data, 32'h3F800000);
      chk("t1_hold_level", {29'd0, level}, 32'd1);
    end
    pop_one();
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // 2: classification
    vec[0] = 32'h80000000; cls[0] = 3'd0;
    vec[1] = 32'h00000001; cls[1] = 3'd1;
    vec[2] = 32'h7F800000; cls[2] = 3'd3;
    vec[3] = 32'h7FC00000; cls[3] = 3'd4;
    for (int i = 0; i < 4; i++) push(vec[i], 1'b0, 1'b0);
    chk("t2_level", {29'd0, level}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", out_data, vec[i]);
      chk("t2_class", {29'd0, out_class}, {29'd0, cls[i]});
      pop_one();
    end
    chk("t2_empty", {29'd0, level}, 32'd0);
    push(32'h7F800001, 1'b0, 1'b0);
    chk("t2_snan_class", {29'd0, out_class}, 32'd5);
    chk("t2_sticky_nan", {31'd0, sticky_nan}, 32'd1);
    chk("t2_no_ovrf", {31'd0, sticky_ovrf}, 32'd0);
    pop_one();

    // 3: full queue, drop vs. simultaneous pop
    vec[0] = 32'h40400000; vec[1] = 32'h40800000; vec[2] = 32'h40A00000; vec[3] = 32'h40C00000;
    for (int i = 0; i < 4; i++) push(vec[i], 1'b0, 1'b0);
    push(32'h40000000, 1'b0, 1'b0);
    chk("t3_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    chk("t3_sticky_drop", {31'd0, sticky_drop}, 32'd1);
    chk("t3_level", {29'd0, level}, 32'd4);
    chk("t3_head", out_data, 32'h40400000);
    out_ready = 1'b1;
    push(32'h40000000, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("t3_level_pp", {29'd0, level}, 32'd4);
    chk("t3_drop_same", {16'd0, drop_cnt}, 32'd1);
    vec[0] = 32'h40800000; vec[1] = 32'h40A00000; vec[2] = 32'h40C00000; vec[3] = 32'h40000000;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", out_data, vec[i]);
      pop_one();
    end
    chk("t3_empty", {29'd0, level}, 32'd0);

    // 4: flag counters with continuous draining, then clear-with-event
    out_ready = 1'b1;
    push(32'h3F800000, 1'b1, 1'b0);
    chk("t4_head_ovrf", {31'd0, out_ovrf}, 32'd1);
    push(32'h3F800000, 1'b1, 1'b0);
    push(32'h3F800000, 1'b1, 1'b0);
    push(32'h00000010, 1'b0, 1'b1);
    chk("t4_head_udrf", {30'd0, out_ovrf, out_udrf}, 32'd1);
    push(32'h00000010, 1'b0, 1'b1);
    chk("t4_level", {29'd0, level}, 32'd1);
    chk("t4_ovrf_cnt", {16'd0, ovrf_cnt}, 32'd3);
    chk("t4_udrf_cnt", {16'd0, udrf_cnt}, 32'd2);
    chk("t4_sticky", {30'd0, sticky_ovrf, sticky_udrf}, 32'd3);
    clr_stat = 1'b1;
    push(32'h3F800000, 1'b1, 1'b0);
    clr_stat = 1'b0;
    chk("t4_clr_ovrf_cnt", {16'd0, ovrf_cnt}, 32'd1);
    chk("t4_clr_udrf_cnt", {16'd0, udrf_cnt}, 32'd0);
    chk("t4_clr_sticky", {28'd0, sticky_ovrf, sticky_udrf, sticky_nan, sticky_drop}, 32'h8);
    chk("t4_clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    tick();
    out_ready = 1'b0;
    chk("t4_fifo_empty", {29'd0, level}, 32'd0);

    // 5: saturation on the 4-bit instance
    in_valid4 = 1'b1; ovrf4 = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("t5_cnt14", {28'd0, ovrf_cnt4}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_sat", {28'd0, ovrf_cnt4}, 32'd15);
    in_valid4 = 1'b0; ovrf4 = 1'b0;
    tick(); tick();
    chk("t5_hold", {28'd0, ovrf_cnt4}, 32'd15);
    chk("t5_level4", {29'd0, level4}, 32'd0);

    // 6: asynchronous reset mid-cycle
    push(32'h3F800000, 1'b0, 1'b1);
    push(32'h40000000, 1'b0, 1'b0);
    push(32'h40400000, 1'b0, 1'b0);
    chk("t6_pre_level", {29'd0, level}, 32'd3);
    #3 rstn = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_level", {29'd0, level}, 32'd0);
    chk("t6_cnts", {ovrf_cnt, udrf_cnt}, 32'd0);
    chk("t6_sticky", {28'd0, sticky_ovrf, sticky_udrf, sticky_nan, sticky_drop}, 32'd0);
    chk("t6_cnt4", {28'd0, ovrf_cnt4}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    push(32'h3F800000, 1'b0, 1'b0);
    chk("t6_post_level", {29'd0, level}, 32'd1);
    chk("t6_post_data", out_data, 32'h3F800000);
    chk("t6_post_class", {29'd0, out_class}, 32'd2);
    pop_one();
    chk("t6_post_empty", {29'd0, level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpmul_result_q.md
Name: fpmul_result_q

Overview:
Downstream result stage for the FP32 multiplier. Captures each result word (fp_Z) and its ovrf/udrf flags on a valid strobe, classifies the IEEE-754 value, and buffers entries in a small FIFO with a valid/ready output port. Maintains sticky exception flags and saturating event counters for status readout. The multiplier has no backpressure, so a push into a full queue is a counted drop.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, 16, width of each saturating event counter.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  fp_Z/ovrf/udrf valid this cycle
fp_Z  in  32  multiplier result word
ovrf  in  1  multiplier overflow flag
udrf  in  1  multiplier underflow flag
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_data  out  32  head result word
out_class  out  3  head class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
out_ovrf  out  1  head overflow flag
out_udrf  out  1  head underflow flag
level  out  $clog2(DEPTH)+1  current occupancy
clr_stat  in  1  synchronous clear of sticky flags and counters
sticky_ovrf  out  1  any accepted entry had ovrf
sticky_udrf  out  1  any accepted entry had udrf
sticky_nan  out  1  any accepted entry classified 4 or 5
sticky_drop  out  1  any push lost to a full queue
ovrf_cnt  out  CNT_W  accepted entries with ovrf
udrf_cnt  out  CNT_W  accepted entries with udrf
drop_cnt  out  CNT_W  dropped pushes

Behaviour:
- Reset (rstn low, async): all outputs 0, read/write pointers 0, storage contents don't-care. On deassertion, in_valid is sampled from the next rising edge.
- Classification is combinational on fp_Z at push; the class is stored with the entry. Let exp = fp_Z[30:23] and man = fp_Z[22:0].
  - exp = 0: man = 0 gives class 0, otherwise class 1.
  - exp = 0xFF: man = 0 gives class 3; man[22] = 1 gives class 4; otherwise class 5.
  - Else class 2. Sign is ignored for class.
- Push: in_valid=1 and (level<DEPTH or pop in same cycle) writes the entry at the edge. out_valid rises the cycle after a push into an empty queue (1-cycle latency, no bypass).
- Pop: out_valid && out_ready at the edge advances the head.
- Stability: out_data, out_class, out_ovrf and out_udrf must hold while out_valid && !out_ready.
- Full, with push and pop in the same cycle: the push is accepted and level stays DEPTH.
- Full, with push and no pop: the entry is discarded, drop_cnt increments and sticky_drop sets. Queue contents are unchanged.
- Empty, with pop attempted: no effect because out_valid=0. Push on empty with out_ready=1: entry appears next cycle and is not popped in the same cycle.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. level is tracked explicitly, so full and empty are distinguishable.
- Sticky flags and counters update only on accepted pushes, except drop_cnt and sticky_drop, which update on drops.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr_stat=1: flags and counters go to 0 at the edge. If an event occurs in the same cycle, the clear applies first and then the event, so the affected flag reads 1 and the counter reads 1.
- clr_stat does not affect FIFO contents.

Test Plan:
1. Reset, then push 0x3F800000 (ovrf=0, udrf=0) with out_ready=0 -> next cycle out_valid=1, out_data=0x3F800000, out_class=2, level=1. Hold for 5 cycles -> outputs unchanged.
2. Push 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000 (out_ready=0), then drain -> classes 0,1,3,4 in order. Push 0x7F800001 -> class 5. sticky_nan=1.
3. Fill 4 entries, push 0x40000000 with out_ready=0 -> drop_cnt=1, sticky_drop=1, level=4, head unchanged. Repeat with out_ready=1 -> push accepted, level=4, drop_cnt stays 1.
4. Push 3 entries with ovrf=1 and 2 with udrf=1 while continuously draining -> ovrf_cnt=3, udrf_cnt=2, both sticky flags 1. Assert clr_stat together with an ovrf push -> ovrf_cnt=1, udrf_cnt=0, sticky_ovrf=1, sticky_udrf=0.
5. CNT_W=4: 20 ovrf pushes -> ovrf_cnt=15, holds at 15.
6. Push 3 entries, assert rstn=0 asynchronously mid-cycle -> out_valid, level, counters and sticky flags go to 0 immediately. After release, push 0x3F800000 -> single entry, class 2.
